// File: rtl/burst_pkg.sv
// Shared types and width helpers for the sliding-window burst detector.
package burst_pkg;

   // Detector phases: filling the window, waiting for a burst, in a burst,
   // and ignoring samples after a burst ended.
   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_BURST   = 2'd2,
      ST_HOLDOFF = 2'd3
   } burst_state_e;

   // Burst polarity selected by the mode input.
   localparam logic MODE_BELOW = 1'b0;
   localparam logic MODE_ABOVE = 1'b1;

   // Width needed to hold a window length of 0..max_win.
   function automatic int calc_win_w(input int max_win);
      return $clog2(max_win + 1);
   endfunction

   // Width of an accumulator that can never overflow for a full window.
   function automatic int calc_acc_w(input int width, input int max_win);
      return width + $clog2(max_win + 1);
   endfunction

endpackage

// File: rtl/window_delay_line.sv
// Circular sample store for the sliding window. The read port returns the
// sample written win_len accepts ago. It is read before the write at the
// same edge, so win_len == MAX_WIN returns the entry about to be replaced.
module window_delay_line
   import burst_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MAX_WIN = 16,
   parameter int WIN_W   = calc_win_w(MAX_WIN)
) (
   input  logic             clock,
   input  logic             ss_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIN_W-1:0] win_len,
   output logic [WIDTH-1:0] rd_data
);

   localparam int PTR_W = (MAX_WIN > 1) ? $clog2(MAX_WIN) : 1;

   logic [WIDTH-1:0] mem_r [MAX_WIN];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [WIN_W:0]   rd_idx_s;
   logic [PTR_W-1:0] rd_ptr_s;

   // Read index is (wr_ptr - win_len) mod MAX_WIN, computed without going negative
   always_comb begin
      rd_idx_s = (WIN_W+1)'(wr_ptr_r) + (WIN_W+1)'(MAX_WIN) - (WIN_W+1)'(win_len);
      if (rd_idx_s >= (WIN_W+1)'(MAX_WIN)) begin
         rd_idx_s = rd_idx_s - (WIN_W+1)'(MAX_WIN);
      end else begin
         rd_idx_s = rd_idx_s;
      end
      rd_ptr_s = PTR_W'(rd_idx_s);
   end

   assign rd_data = mem_r[rd_ptr_s];

   // Write pointer: wraps at the last entry, restarts on a window restart
   always_ff @(posedge clock or negedge ss_n) begin
      if (!ss_n) begin
         wr_ptr_r <= '0;
      end else if (clear) begin
         wr_ptr_r <= '0;
      end else if (wr_en) begin
         if (wr_ptr_r == PTR_W'(MAX_WIN - 1)) begin
            wr_ptr_r <= '0;
         end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Sample storage; stale contents after a restart are never read because
   // eviction only happens once the window has been refilled
   always_ff @(posedge clock or negedge ss_n) begin
      if (!ss_n) begin
         for (int i = 0; i < MAX_WIN; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en && !clear) begin
         mem_r[wr_ptr_r] <= wr_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

endmodule

// File: rtl/burst_window_detector.sv
// Sliding-window burst detector: running sum of the last win_len accepted
// samples, hysteresis thresholds with selectable polarity, and a holdoff
// period after each burst. All outputs are registered with one-cycle latency.
module burst_window_detector
   import burst_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MAX_WIN = 16,
   parameter int HOLD_W  = 8,
   parameter int WIN_W   = calc_win_w(MAX_WIN),
   parameter int ACC_W   = calc_acc_w(WIDTH, MAX_WIN)
) (
   input  logic              clock,
   input  logic              ss_n,
   input  logic              din_valid,
   input  logic [WIDTH-1:0]  din,
   input  logic              cfg_load,
   input  logic [WIN_W-1:0]  win_len,
   input  logic              mode,
   input  logic [ACC_W-1:0]  thr_on,
   input  logic [ACC_W-1:0]  thr_off,
   input  logic [HOLD_W-1:0] holdoff,
   output logic [ACC_W-1:0]  window_sum,
   output logic              window_full,
   output logic              burst_detected,
   output logic              burst_start,
   output logic              burst_end
);

   burst_state_e      state_r, state_nxt_s;
   logic [WIN_W-1:0]  win_len_q_r, win_len_clamped_s;
   logic              mode_q_r;
   logic [WIN_W-1:0]  fill_r, next_fill_s;
   logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
   logic [ACC_W-1:0]  sum_r, next_sum_s, evicted_s;
   logic [WIDTH-1:0]  rd_data_s;
   logic              accept_s, full_now_s, on_s, off_s, start_s, end_s;
   logic              full_r, detected_r, start_r, end_r;

   // A restart takes priority over a sample presented in the same cycle
   assign accept_s = din_valid & ~cfg_load;

   window_delay_line #(
      .WIDTH   (WIDTH),
      .MAX_WIN (MAX_WIN),
      .WIN_W   (WIN_W)
   ) u_delay (
      .clock   (clock),
      .ss_n    (ss_n),
      .clear   (cfg_load),
      .wr_en   (accept_s),
      .wr_data (din),
      .win_len (win_len_q_r),
      .rd_data (rd_data_s)
   );

   // Clamp the requested window length into 1..MAX_WIN
   always_comb begin
      if (win_len == '0) begin
         win_len_clamped_s = WIN_W'(1);
      end else if (win_len > WIN_W'(MAX_WIN)) begin
         win_len_clamped_s = WIN_W'(MAX_WIN);
      end else begin
         win_len_clamped_s = win_len;
      end
   end

   // Running sum update and threshold decisions for the incoming sample
   always_comb begin
      full_now_s = (fill_r == win_len_q_r);
      if (full_now_s) begin
         evicted_s   = ACC_W'(rd_data_s);
         next_fill_s = fill_r;
      end else begin
         evicted_s   = '0;
         next_fill_s = fill_r + WIN_W'(1);
      end
      next_sum_s = sum_r + ACC_W'(din) - evicted_s;
      if (mode_q_r == MODE_ABOVE) begin
         on_s  = (next_sum_s >= thr_on);
         off_s = (next_sum_s <  thr_off);
      end else begin
         on_s  = (next_sum_s <  thr_on);
         off_s = (next_sum_s >= thr_off);
      end
   end

   // Phase transitions, event pulses and holdoff count for an accepted sample
   always_comb begin
      state_nxt_s    = state_r;
      hold_cnt_nxt_s = hold_cnt_r;
      start_s        = 1'b0;
      end_s          = 1'b0;
      if (accept_s) begin
         case (state_r)
            ST_FILL: begin
               if (next_fill_s == win_len_q_r) begin
                  if (on_s) begin
                     state_nxt_s = ST_BURST;
                     start_s     = 1'b1;
                  end else begin
                     state_nxt_s = ST_ARMED;
                  end
               end else begin
                  state_nxt_s = ST_FILL;
               end
            end
            ST_ARMED: begin
               if (on_s) begin
                  state_nxt_s = ST_BURST;
                  start_s     = 1'b1;
               end else begin
                  state_nxt_s = ST_ARMED;
               end
            end
            ST_BURST: begin
               if (off_s) begin
                  end_s = 1'b1;
                  if (holdoff == '0) begin
                     state_nxt_s = ST_ARMED;
                  end else begin
                     state_nxt_s    = ST_HOLDOFF;
                     hold_cnt_nxt_s = holdoff;
                  end
               end else begin
                  state_nxt_s = ST_BURST;
               end
            end
            ST_HOLDOFF: begin
               // The sample that drains the count is consumed, not evaluated
               if (hold_cnt_r <= HOLD_W'(1)) begin
                  state_nxt_s    = ST_ARMED;
                  hold_cnt_nxt_s = '0;
               end else begin
                  state_nxt_s    = ST_HOLDOFF;
                  hold_cnt_nxt_s = hold_cnt_r - HOLD_W'(1);
               end
            end
            default: begin
               state_nxt_s    = ST_FILL;
               hold_cnt_nxt_s = '0;
            end
         endcase
      end else begin
         state_nxt_s    = state_r;
         hold_cnt_nxt_s = hold_cnt_r;
      end
   end

   // Configuration latch, window restart, and per-sample state/output update
   always_ff @(posedge clock or negedge ss_n) begin
      if (!ss_n) begin
         state_r     <= ST_FILL;
         win_len_q_r <= WIN_W'(1);
         mode_q_r    <= MODE_BELOW;
         fill_r      <= '0;
         hold_cnt_r  <= '0;
         sum_r       <= '0;
         full_r      <= 1'b0;
         detected_r  <= 1'b0;
         start_r     <= 1'b0;
         end_r       <= 1'b0;
      end else if (cfg_load) begin
         state_r     <= ST_FILL;
         win_len_q_r <= win_len_clamped_s;
         mode_q_r    <= mode;
         fill_r      <= '0;
         hold_cnt_r  <= '0;
         sum_r       <= '0;
         full_r      <= 1'b0;
         detected_r  <= 1'b0;
         start_r     <= 1'b0;
         end_r       <= 1'b0;
      end else if (accept_s) begin
         state_r     <= state_nxt_s;
         fill_r      <= next_fill_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
         sum_r       <= next_sum_s;
         full_r      <= (next_fill_s == win_len_q_r);
         detected_r  <= (state_nxt_s == ST_BURST);
         start_r     <= start_s;
         end_r       <= end_s;
      end else begin
         start_r     <= 1'b0;
         end_r       <= 1'b0;
      end
   end

   assign window_sum     = sum_r;
   assign window_full    = full_r;
   assign burst_detected = detected_r;
   assign burst_start    = start_r;
   assign burst_end      = end_r;

endmodule

// File: tb/tb_burst_window_detector.sv
// Randomized and directed bench for burst_window_detector, checked against a
// queue-based reference model of the windowed sum and burst phases.
module tb_burst_window_detector;

   localparam int WIDTH   = 8;
   localparam int MAX_WIN = 16;
   localparam int HOLD_W  = 8;
   localparam int WIN_W   = 5;
   localparam int ACC_W   = 13;

   localparam int P_FILL  = 0;
   localparam int P_ARMED = 1;
   localparam int P_BURST = 2;
   localparam int P_HOLD  = 3;

   logic              clock = 1'b0;
   logic              ss_n;
   logic              din_valid;
   logic [WIDTH-1:0]  din;
   logic              cfg_load;
   logic [WIN_W-1:0]  win_len;
   logic              mode;
   logic [ACC_W-1:0]  thr_on;
   logic [ACC_W-1:0]  thr_off;
   logic [HOLD_W-1:0] holdoff;
   logic [ACC_W-1:0]  window_sum;
   logic              window_full;
   logic              burst_detected;
   logic              burst_start;
   logic              burst_end;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_q[$];
   int m_wl;
   int m_mode;
   int m_phase;
   int m_cnt;
   int e_sum;
   int e_full, e_det, e_start, e_end;

   burst_window_detector #(
      .WIDTH(WIDTH), .MAX_WIN(MAX_WIN), .HOLD_W(HOLD_W)
   ) dut (
      .clock          (clock),
      .ss_n           (ss_n),
      .din_valid      (din_valid),
      .din            (din),
      .cfg_load       (cfg_load),
      .win_len        (win_len),
      .mode           (mode),
      .thr_on         (thr_on),
      .thr_off        (thr_off),
      .holdoff        (holdoff),
      .window_sum     (window_sum),
      .window_full    (window_full),
      .burst_detected (burst_detected),
      .burst_start    (burst_start),
      .burst_end      (burst_end)
   );

   // free-running clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int clamp_len(input int wl);
      if (wl == 0) return 1;
      if (wl > MAX_WIN) return MAX_WIN;
      return wl;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_wl = 1; m_mode = 0; m_phase = P_FILL; m_cnt = 0;
      e_sum = 0; e_full = 0; e_det = 0; e_start = 0; e_end = 0;
   endtask

   // Expected outputs after the next edge, from the current inputs
   task automatic model_step();
      int s;
      bit on, off;
      e_start = 0; e_end = 0;
      if (cfg_load) begin
         m_wl = clamp_len(int'(win_len));
         m_mode = int'(mode);
         m_q.delete();
         m_phase = P_FILL; m_cnt = 0;
         e_sum = 0; e_full = 0; e_det = 0;
      end else if (din_valid) begin
         m_q.push_back(int'(din));
         if (m_q.size() > m_wl) void'(m_q.pop_front());
         s = 0;
         foreach (m_q[i]) s += m_q[i];
         e_sum = s;
         e_full = (m_q.size() == m_wl);
         on  = m_mode ? (s >= int'(thr_on))  : (s <  int'(thr_on));
         off = m_mode ? (s <  int'(thr_off)) : (s >= int'(thr_off));
         case (m_phase)
            P_FILL:  if (e_full) begin
                        if (on) begin m_phase = P_BURST; e_start = 1; end
                        else m_phase = P_ARMED;
                     end
            P_ARMED: if (on) begin m_phase = P_BURST; e_start = 1; end
            P_BURST: if (off) begin
                        e_end = 1;
                        if (holdoff == 0) m_phase = P_ARMED;
                        else begin m_phase = P_HOLD; m_cnt = int'(holdoff); end
                     end
            default: begin
                        m_cnt--;
                        if (m_cnt == 0) m_phase = P_ARMED;
                     end
         endcase
         e_det = (m_phase == P_BURST);
      end
   endtask

   task automatic compare_all();
      check_value("window_sum", 32'(window_sum), 32'(e_sum));
      check_value("window_full", 32'(window_full), 32'(e_full));
      check_value("burst_detected", 32'(burst_detected), 32'(e_det));
      check_value("burst_start", 32'(burst_start), 32'(e_start));
      check_value("burst_end", 32'(burst_end), 32'(e_end));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      compare_all();
   endtask

   task automatic sample(input int d);
      cfg_load = 1'b0; din_valid = 1'b1; din = WIDTH'(d);
      cycle();
   endtask

   task automatic idle();
      cfg_load = 1'b0; din_valid = 1'b0;
      cycle();
   endtask

   task automatic configure(input int wl, input int md);
      cfg_load = 1'b1; din_valid = 1'b0; win_len = WIN_W'(wl); mode = md[0];
      cycle();
      cfg_load = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_value({tag, "_sum"}, 32'(window_sum), 32'd0);
      check_value({tag, "_flags"}, 32'({window_full, burst_detected, burst_start, burst_end}), 32'd0);
   endtask

   initial begin
      int wl, r;
      ss_n = 1'b0; din_valid = 1'b0; din = '0; cfg_load = 1'b0;
      win_len = '0; mode = 1'b0; thr_on = '0; thr_off = '0; holdoff = '0;
      model_reset();
      #2;
      check_outputs_zero("reset");
      @(posedge clock); #1;
      check_outputs_zero("reset_hold");
      #2 ss_n = 1'b1;

      // high burst with hysteresis, no holdoff
      thr_on = 13'd100; thr_off = 13'd60; holdoff = 8'd0;
      configure(4, 1);
      sample(30); sample(30); sample(30);
      check_value("t2_not_full", 32'(window_full), 32'd0);
      sample(30);
      check_value("t2_sum120", 32'(window_sum), 32'd120);
      check_value("t2_start", 32'(burst_start), 32'd1);
      sample(0); sample(0);
      check_value("t2_sum60", 32'(window_sum), 32'd60);
      check_value("t2_no_end60", 32'(burst_end), 32'd0);
      sample(0);
      check_value("t2_end30", 32'(burst_end), 32'd1);

      // reset between edges while in a burst
      configure(4, 1);
      repeat (4) sample(40);
      check_value("t1_in_burst", 32'(burst_detected), 32'd1);
      #2 ss_n = 1'b0;
      #1;
      check_outputs_zero("t1_async");
      model_reset();
      #2 ss_n = 1'b1;
      configure(4, 1);
      repeat (3) sample(10);
      check_value("t1_not_full", 32'(window_full), 32'd0);
      sample(10);
      check_value("t1_full", 32'(window_full), 32'd1);

      // full-depth window, wrap and read-before-write
      thr_on = 13'd8000; thr_off = 13'd0;
      configure(16, 1);
      repeat (16) sample(255);
      check_value("t3_sum4080", 32'(window_sum), 32'd4080);
      sample(0);
      check_value("t3_sum3825", 32'(window_sum), 32'd3825);

      // low burst with inverted-looking thresholds
      thr_on = 13'd50; thr_off = 13'd80;
      configure(2, 0);
      sample(100); sample(100); sample(0);
      sample(0);
      check_value("t4_start", 32'(burst_start), 32'd1);
      sample(45);
      sample(45);
      check_value("t4_sum90", 32'(window_sum), 32'd90);
      check_value("t4_end", 32'(burst_end), 32'd1);

      // holdoff with valid gaps
      thr_on = 13'd100; thr_off = 13'd60; holdoff = 8'd3;
      configure(4, 1);
      repeat (4) sample(30);
      sample(0); idle(); sample(0); sample(0);
      check_value("t5_end", 32'(burst_end), 32'd1);
      sample(100); idle(); idle(); sample(100); idle(); sample(100);
      check_value("t5_ignored", 32'(burst_detected), 32'd0);
      idle();
      sample(100);
      check_value("t5_start", 32'(burst_start), 32'd1);

      // restart during a burst with a coincident sample
      cfg_load = 1'b1; din_valid = 1'b1; din = 8'd200; win_len = 5'd4; mode = 1'b1;
      cycle();
      cfg_load = 1'b0;
      check_outputs_zero("t6_restart");

      // randomized segments
      for (int seg = 0; seg < 30; seg++) begin
         wl = $urandom_range(0, 20);
         configure(wl, $urandom_range(0, 1));
         wl = clamp_len(wl);
         thr_on  = ACC_W'($urandom_range(0, wl * 255));
         thr_off = ACC_W'($urandom_range(0, wl * 255));
         holdoff = HOLD_W'($urandom_range(0, 4));
         for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
               thr_on  = ACC_W'($urandom_range(0, wl * 255));
               thr_off = ACC_W'($urandom_range(0, wl * 255));
            end
            if (r < 70) begin
               sample($urandom_range(0, 255));
            end else if (r < 72) begin
               cfg_load = 1'b1; din_valid = 1'($urandom_range(0, 1));
               din = WIDTH'($urandom_range(0, 255));
               win_len = WIN_W'(wl); mode = 1'($urandom_range(0, 1));
               cycle();
               cfg_load = 1'b0;
            end else begin
               idle();
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
